// File: rtl/hl_rmii_pkg.sv
// Shared types and constants for the RMII transmit serializer.
package hl_rmii_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XMIT = 2'd1,
        IPG  = 2'd2
    } tx_state_t;

    localparam int DIV100              = 1;
    localparam int DIV10_DEFAULT       = 10;
    localparam int IPG_NIBBLES_DEFAULT = 24;
    localparam int STATS_W             = 16;

endpackage

// File: rtl/rmii_tx_timebase.sv
// Dibit/nibble strobe generator for the 50 MHz RMII domain; speed is latched
// only at nibble boundaries so a nibble never changes rate halfway through.
module rmii_tx_timebase
    import hl_rmii_pkg::*;
#(
    parameter int DIV10 = DIV10_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic speed_100,
    output logic dibit_stb,
    output logic nibble_stb,
    output logic speed_lat
);

    localparam int CW = (DIV10 > 2) ? $clog2(DIV10) : 1;

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] reload;
    logic          phase;
    logic          use_fast;

    assign dibit_stb  = (div_cnt == '0);
    assign nibble_stb = dibit_stb & phase;

    // The dibit starting at a nibble boundary already runs at the newly sampled speed.
    // NOTE: every always_comb output gets a default/complete assignment so no latch is inferred.
    always_comb begin
        use_fast = nibble_stb ? speed_100 : speed_lat;
        reload   = use_fast ? CW'(DIV100 - 1) : CW'(DIV10 - 1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            phase     <= 1'b0;
            speed_lat <= 1'b1;
        end else if (dibit_stb) begin
            div_cnt <= reload;
            phase   <= ~phase;
            if (nibble_stb) begin
                speed_lat <= speed_100;
            end
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/rmii_tx_serializer.sv
// MII-to-RMII transmit serializer with inter-packet-gap guard.
// Optional frame statistics are built only when RMII_TX_STATS_EN is defined.
module rmii_tx_serializer
    import hl_rmii_pkg::*;
#(
    parameter int IPG_NIBBLES = IPG_NIBBLES_DEFAULT,
    parameter int DIV10       = DIV10_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        speed_100,
    output logic        mac_tx_ce,
    input  logic [3:0]  mac_txd,
    input  logic        mac_tx_en,
    output logic [1:0]  rmii_tx,
    output logic        rmii_tx_en,
    output logic        ipg_hold,
    output logic [15:0] frame_count,
    output logic        odd_nibble_err
);

    localparam int IW = (IPG_NIBBLES > 2) ? $clog2(IPG_NIBBLES) : 1;

    logic          dibit_stb;
    logic          nibble_stb;
    logic          speed_lat;
    logic          capture;
    tx_state_t     state, state_nx;
    logic [IW-1:0] ipg_cnt, ipg_cnt_nx;
    logic [1:0]    hold_hi;

    rmii_tx_timebase #(.DIV10(DIV10)) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .speed_100  (speed_100),
        .dibit_stb  (dibit_stb),
        .nibble_stb (nibble_stb),
        .speed_lat  (speed_lat)
    );

    assign capture   = nibble_stb && (state != IPG);
    assign mac_tx_ce = capture;
    assign ipg_hold  = (state == IPG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ipg_cnt <= '0;
        end else begin
            state   <= state_nx;
            ipg_cnt <= ipg_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ipg_cnt_nx = ipg_cnt;
        case (state)
            IDLE: begin
                if (capture && mac_tx_en) begin
                    state_nx = XMIT;
                end
            end
            XMIT: begin
                if (capture && !mac_tx_en) begin
                    state_nx   = IPG;
                    ipg_cnt_nx = IW'(IPG_NIBBLES - 1);
                end
            end
            IPG: begin
                if (nibble_stb) begin
                    if (ipg_cnt == '0) begin
                        state_nx = IDLE;
                    end else begin
                        ipg_cnt_nx = ipg_cnt - 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The low dibit goes straight out on the capture edge; only the high dibit needs holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_hi    <= 2'b00;
            rmii_tx_en <= 1'b0;
            rmii_tx    <= 2'b00;
        end else if (capture) begin
            hold_hi    <= mac_txd[3:2];
            rmii_tx_en <= mac_tx_en;
            rmii_tx    <= mac_tx_en ? mac_txd[1:0] : 2'b00;
        end else if (dibit_stb) begin
            rmii_tx    <= rmii_tx_en ? hold_hi : 2'b00;
        end
    end

`ifdef RMII_TX_STATS_EN
    logic               frame_end;
    logic [STATS_W-1:0] frame_cnt_q;
    logic               parity_q;
    logic               odd_err_q;

    assign frame_end = (state == XMIT) && capture && !mac_tx_en;

    // parity_q is 1 while the current frame holds an odd number of nibbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            parity_q    <= 1'b0;
            odd_err_q   <= 1'b0;
        end else begin
            if (capture && mac_tx_en) begin
                parity_q <= (state == IDLE) ? 1'b1 : ~parity_q;
            end
            if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                if (parity_q) begin
                    odd_err_q <= 1'b1;
                end
            end
        end
    end

    assign frame_count    = frame_cnt_q;
    assign odd_nibble_err = odd_err_q;
`else
    assign frame_count    = '0;
    assign odd_nibble_err = 1'b0;
`endif

endmodule
